arbiter_rr: RTL and testbench

Round-robin arbiter that shares one resource between NUM_PORTS requesters using the 3-way request/grant/acknowledge handshake. Requesters sit on the upstream side, usually each behind its own hold-time limiter. The arbiter drives a one-hot grant and tracks ownership until the owner drops its request. An acknowledge watchdog revokes a grant that is never acknowledged, so a stalled requester cannot lock the resource.

---
 rtl/arbiter_rr_if.sv | 31 +++
 rtl/arbiter_rr.sv | 127 ++++++++++++
 tb/tb_arbiter_rr.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/arbiter_rr_if.sv
// Request/grant/acknowledge bundle shared by the round-robin arbiter.
// The arbiter takes the master view; the requesters take the slave view.
interface arbiter_rr_if #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = $clog2(NUM_PORTS)
);
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] ack;
    logic [NUM_PORTS-1:0] grant;
    logic [IDX_W-1:0]     owner;
    logic                 busy;
    logic                 ack_timeout;

    modport master (
        input  req,
        input  ack,
        output grant,
        output owner,
        output busy,
        output ack_timeout
    );

    modport slave (
        output req,
        output ack,
        input  grant,
        input  owner,
        input  busy,
        input  ack_timeout
    );
endinterface

// File: rtl/arbiter_rr.sv
// Round-robin arbiter with request/grant/acknowledge handshake.
// A watchdog revokes grants that are never acknowledged.
module arbiter_rr #(
    parameter int NUM_PORTS = 4,
    parameter int ACK_WAIT  = 16,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic          clk,
    input  logic          rst,
    arbiter_rr_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        OWN   = 2'd2
    } state_t;

    localparam logic [31:0] WAIT_LAST = 32'(ACK_WAIT - 1);
    localparam logic [IDX_W:0] PORTS_W = (IDX_W+1)'(NUM_PORTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);
    localparam logic [NUM_PORTS-1:0] ONE = NUM_PORTS'(1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [31:0]          wait_q, wait_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic                 to_q, to_d;

    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    logic [IDX_W:0]       pos;
    logic                 own_req;
    logic                 own_ack;
    logic                 release_d;
    logic [IDX_W-1:0]     nxt_ptr;

    assign own_req = bus.req[owner_q];
    assign own_ack = bus.ack[owner_q];
    assign nxt_ptr = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

    // Scan requests starting at ptr, wrapping, first hit wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        pos       = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            pos = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (pos >= PORTS_W) pos = pos - PORTS_W;
            if (!sel_found && bus.req[pos[IDX_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = pos[IDX_W-1:0];
            end
        end
    end

    // Next-state logic: grant, acknowledge window, ownership, release.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wait_d    = wait_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        to_d      = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant_d = ONE << sel_idx;
                    owner_d = sel_idx;
                    wait_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!own_req) begin
                    release_d = 1'b1;
                end else if (own_ack) begin
                    state_d = OWN;
                end else if (ACK_WAIT != 0 && wait_q == WAIT_LAST) begin
                    release_d = 1'b1;
                    to_d      = 1'b1;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            OWN: begin
                if (!own_req) release_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
        if (release_d) begin
            grant_d = '0;
            state_d = IDLE;
            ptr_d   = nxt_ptr;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            wait_q  <= '0;
            grant_q <= '0;
            owner_q <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wait_q  <= wait_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            to_q    <= to_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.owner       = owner_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.ack_timeout = to_q;

endmodule

// File: tb/tb_arbiter_rr.sv
// Scoreboard bench for arbiter_rr: stimulus pushes model expectations,
// a monitor pops and compares one entry per clock.
module tb_arbiter_rr;

    localparam int N  = 4;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    arbiter_rr_if #(.NUM_PORTS(N)) bus ();

    arbiter_rr #(
        .NUM_PORTS(N),
        .ACK_WAIT (AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [N-1:0] grant;
        logic [1:0]   owner;
        logic         busy;
        logic         to;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;

    // Reference model: who holds the resource, whether acked,
    // how many cycles the grant has been visible, where the scan starts.
    bit m_busy  = 0;
    bit m_acked = 0;
    bit m_to    = 0;
    int m_owner = 0;
    int m_age   = 0;
    int m_ptr   = 0;

    function automatic void m_release();
        m_busy  = 0;
        m_acked = 0;
        m_ptr   = (m_owner + 1) % N;
    endfunction

    function automatic void model(input logic r,
                                  input logic [N-1:0] rq,
                                  input logic [N-1:0] ak);
        if (r) begin
            m_busy = 0; m_acked = 0; m_to = 0;
            m_owner = 0; m_age = 0; m_ptr = 0;
            return;
        end
        m_to = 0;
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                int p;
                p = (m_ptr + k) % N;
                if (rq[p]) begin
                    m_busy = 1; m_acked = 0;
                    m_owner = p; m_age = 1;
                    break;
                end
            end
        end else if (!m_acked) begin
            if (!rq[m_owner]) m_release();
            else if (ak[m_owner]) m_acked = 1;
            else if (AW != 0 && m_age == AW) begin
                m_release();
                m_to = 1;
            end else m_age++;
        end else if (!rq[m_owner]) begin
            m_release();
        end
    endfunction

    function automatic exp_t expected();
        exp_t e;
        e.grant = m_busy ? (N'(1) << m_owner) : '0;
        e.owner = 2'(m_owner);
        e.busy  = m_busy;
        e.to    = m_to;
        return e;
    endfunction

    task automatic step(input logic r,
                        input logic [N-1:0] rq,
                        input logic [N-1:0] ak);
        @(negedge clk);
        rst     = r;
        bus.req = rq;
        bus.ack = ak;
        model(r, rq, ak);
        q.push_back(expected());
    endtask

    // Requesters ack immediately and drop req after `hold` owned cycles.
    task automatic run_reactive(input logic [N-1:0] base,
                                input int cycles, input int hold);
        int own_cnt;
        logic [N-1:0] rq, ak;
        own_cnt = 0;
        for (int c = 0; c < cycles; c++) begin
            rq = base;
            ak = '0;
            if (m_busy && m_acked) own_cnt++;
            else own_cnt = 0;
            if (m_busy) begin
                ak = N'(1) << m_owner;
                if (own_cnt >= hold) rq[m_owner] = 1'b0;
            end
            step(1'b0, rq, ak);
        end
    endtask

    task automatic do_reset();
        step(1'b1, '0, '0);
        step(1'b0, '0, '0);
    endtask

    function automatic void chk(input string name,
                                input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t",
                     name, act, exp, $time);
        end
    endfunction

    // Monitor: compare DUT outputs just after each active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("grant", int'(bus.grant), int'(e.grant));
                chk("owner", int'(bus.owner), int'(e.owner));
                chk("busy", int'(bus.busy), int'(e.busy));
                chk("ack_timeout", int'(bus.ack_timeout), int'(e.to));
            end
        end
    end

    initial begin
        logic [N-1:0] rq_r, ak_r;
        bus.req = '0;
        bus.ack = '0;
        do_reset();

        // Single requester on port 2.
        step(1'b0, 4'b0100, 4'b0000);
        step(1'b0, 4'b0100, 4'b0000);
        repeat (5) step(1'b0, 4'b0100, 4'b0100);
        repeat (3) step(1'b0, 4'b0000, 4'b0000);

        // Fairness with all ports requesting.
        do_reset();
        run_reactive(4'b1111, 30, 3);

        // Watchdog: two requesters that never acknowledge.
        do_reset();
        repeat (14) step(1'b0, 4'b0110, 4'b0000);
        repeat (2) step(1'b0, 4'b0000, 4'b0000);

        // Ack arriving on the last cycle of the window.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            ak_r = (m_busy && !m_acked && m_age == AW) ? 4'b0010 : 4'b0000;
            step(1'b0, 4'b0010, ak_r);
        end
        repeat (2) step(1'b0, 4'b0000, 4'b0000);

        // Wrap: leave ptr at 3, then ports 0 and 1 request.
        do_reset();
        run_reactive(4'b0100, 5, 2);
        step(1'b0, 4'b0000, 4'b0000);
        run_reactive(4'b0011, 12, 2);
        step(1'b0, 4'b0000, 4'b0000);
        run_reactive(4'b0100, 5, 2);
        step(1'b0, 4'b0000, 4'b0000);
        run_reactive(4'b1000, 6, 2);

        // Reset while port 2 owns the resource.
        do_reset();
        repeat (4) step(1'b0, 4'b0100, 4'b0100);
        step(1'b1, 4'b0100, 4'b0100);
        run_reactive(4'b1111, 12, 2);

        // Randomised traffic with occasional resets.
        rq_r = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(7) == 0) rq_r[i] = ~rq_r[i];
            ak_r = ($urandom_range(2) == 0) ? N'($urandom) : '0;
            step(($urandom_range(199) == 0), rq_r, ak_r);
        end

        @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
